pattern_scheduler: RTL and testbench

//  Playlist sequencer for the VGA pattern generators. Owns the active-pattern index,
//  per-pattern programmable dwell times (in frames), manual next and pause controls.

---
 rtl/pattern_scheduler_if.sv | 32 +++
 rtl/pattern_scheduler.sv | 126 ++++++++++++
 tb/tb_pattern_scheduler.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pattern_scheduler_if.sv
// Signal bundle between the VGA timing/control front end and the pattern scheduler.
// The master drives timing, buttons and configuration; the slave (scheduler) drives pattern control.
interface pattern_scheduler_if #(
   parameter int NUM_PATTERNS = 4,
   parameter int SEL_W        = 2,
   parameter int FRAME_W      = 10
);
   logic [9:0]              x;
   logic [9:0]              y;
   logic                    vsync;
   logic                    btn_next;
   logic                    btn_pause;
   logic                    cfg_we;
   logic [SEL_W-1:0]        cfg_idx;
   logic [FRAME_W-1:0]      cfg_frames;
   logic [SEL_W-1:0]        pattern_select;
   logic [NUM_PATTERNS-1:0] pattern_enable;
   logic [NUM_PATTERNS-1:0] next_frame;
   logic                    paused;
   logic                    switch_pending;
   logic [FRAME_W-1:0]      frame_count;

   modport master (
      output x, y, vsync, btn_next, btn_pause, cfg_we, cfg_idx, cfg_frames,
      input  pattern_select, pattern_enable, next_frame, paused, switch_pending, frame_count
   );

   modport slave (
      input  x, y, vsync, btn_next, btn_pause, cfg_we, cfg_idx, cfg_frames,
      output pattern_select, pattern_enable, next_frame, paused, switch_pending, frame_count
   );
endinterface

// File: rtl/pattern_scheduler.sv
// Playlist sequencer for the VGA pattern generators: per-pattern dwell in frames, manual
// next/pause, and pattern switches deferred to the frame origin so no frame is torn.
//
// state | meaning
// ------+-------------------------------------------------------------------
// RUN   | counting frames on the active pattern, waiting for expiry or next
// PEND  | switch requested; frame count frozen until pixel (0,0)
module pattern_scheduler #(
   parameter int NUM_PATTERNS   = 4,
   parameter int SEL_W          = 2,
   parameter int FRAME_W        = 10,
   parameter int DEFAULT_FRAMES = 240
) (
   input logic                 clk,
   input logic                 rst_n,
   pattern_scheduler_if.slave  bus
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_PEND = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic [SEL_W-1:0]        sel_q, sel_d;
   logic [FRAME_W-1:0]      fc_q, fc_d;
   logic                    paused_q;
   logic                    vsync_q;
   logic [NUM_PATTERNS-1:0] nf_q;
   logic [NUM_PATTERNS-1:0] enable;
   logic [FRAME_W-1:0]      dwell_q [NUM_PATTERNS];

   logic                    vs_rise;
   logic                    tick;
   logic                    origin;
   logic                    expire;
   logic                    cfg_hit;
   logic [FRAME_W-1:0]      dwell_cur;
   logic [FRAME_W-1:0]      fc_inc;

   assign vs_rise   = bus.vsync & ~vsync_q;
   assign tick      = vs_rise & ~paused_q;
   assign origin    = (bus.x == 10'd0) && (bus.y == 10'd0);
   assign cfg_hit   = bus.cfg_we && (int'(bus.cfg_idx) < NUM_PATTERNS);
   assign dwell_cur = dwell_q[sel_q];
   // A dwell of zero means hold forever, so it never expires.
   assign expire    = (dwell_cur != '0) && (fc_q >= (dwell_cur - FRAME_W'(1)));
   assign fc_inc    = (fc_q == '1) ? fc_q : fc_q + FRAME_W'(1);

   always_comb begin
      enable = '0;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
         enable[i] = (sel_q == SEL_W'(i));
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      fc_d    = fc_q;
      case (state_q)
         ST_RUN: begin
            if (tick) begin
               if (expire) begin
                  fc_d    = '0;
                  state_d = ST_PEND;
               end else begin
                  fc_d = fc_inc;
               end
            end
            if (bus.btn_next) begin
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            if (origin) begin
               sel_d   = (sel_q == SEL_W'(NUM_PATTERNS - 1)) ? '0 : sel_q + SEL_W'(1);
               fc_d    = '0;
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_RUN;
         sel_q    <= '0;
         fc_q     <= '0;
         paused_q <= 1'b0;
         vsync_q  <= 1'b1;
         nf_q     <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         fc_q     <= fc_d;
         vsync_q  <= bus.vsync;
         // Uses the pre-switch enable, so a tick coinciding with a switch goes to the outgoing pattern.
         nf_q     <= tick ? enable : '0;
         if (bus.btn_pause) begin
            paused_q <= ~paused_q;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PATTERNS; i++) begin
            dwell_q[i] <= FRAME_W'(DEFAULT_FRAMES);
         end
      end else if (cfg_hit) begin
         dwell_q[bus.cfg_idx] <= bus.cfg_frames;
      end
   end

   assign bus.pattern_select = sel_q;
   assign bus.pattern_enable = enable;
   assign bus.next_frame     = nf_q;
   assign bus.paused         = paused_q;
   assign bus.switch_pending = (state_q == ST_PEND);
   assign bus.frame_count    = fc_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed, table-driven bench for pattern_scheduler: each record applies one operation
// and lists the hand-computed select/enable/count/pending/pause and next_frame activity.
module tb_pattern_scheduler;

   localparam int NUM_PATTERNS = 4;
   localparam int SEL_W        = 2;
   localparam int FRAME_W      = 10;

   typedef enum int {
      OP_FRAMES, OP_ORIGIN, OP_CFG, OP_PAUSE, OP_NEXT, OP_NEXT_FRAME, OP_ORIGIN_FRAME, OP_PAUSE_ORIGIN
   } op_e;

   typedef struct {
      op_e op;
      int  a;
      int  b;
      int  sel;
      int  en;
      int  fc;
      int  pend;
      int  paused;
      int  nf;
      int  nf_last;
   } vec_t;

   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;
   int   nf_cnt;
   int   nf_last;
   vec_t vecs[$];

   pattern_scheduler_if #(.NUM_PATTERNS(NUM_PATTERNS), .SEL_W(SEL_W), .FRAME_W(FRAME_W)) bus ();

   pattern_scheduler #(
      .NUM_PATTERNS(NUM_PATTERNS), .SEL_W(SEL_W), .FRAME_W(FRAME_W), .DEFAULT_FRAMES(240)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.next_frame != '0) begin
         nf_cnt++;
         nf_last = int'(bus.next_frame);
         chk("nf_onehot", int'($onehot(bus.next_frame)), 1);
      end
   end

   task automatic frame_low();
      bus.vsync = 1'b0;
      @(negedge clk);
      bus.vsync = 1'b1;
   endtask

   task automatic run_op(input op_e op, input int a, input int b);
      case (op)
         OP_FRAMES: begin
            for (int i = 0; i < a; i++) begin
               frame_low();
               @(negedge clk);
            end
         end
         OP_ORIGIN: begin
            bus.x = 10'd0; bus.y = 10'd0;
            @(negedge clk);
            bus.x = 10'd5; bus.y = 10'd5;
         end
         OP_CFG: begin
            bus.cfg_we = 1'b1; bus.cfg_idx = SEL_W'(a); bus.cfg_frames = FRAME_W'(b);
            @(negedge clk);
            bus.cfg_we = 1'b0;
         end
         OP_PAUSE: begin
            bus.btn_pause = 1'b1;
            @(negedge clk);
            bus.btn_pause = 1'b0;
         end
         OP_NEXT: begin
            bus.btn_next = 1'b1;
            @(negedge clk);
            bus.btn_next = 1'b0;
         end
         OP_NEXT_FRAME: begin
            frame_low();
            bus.btn_next = 1'b1;
            @(negedge clk);
            bus.btn_next = 1'b0;
         end
         OP_ORIGIN_FRAME: begin
            frame_low();
            bus.x = 10'd0; bus.y = 10'd0;
            @(negedge clk);
            bus.x = 10'd5; bus.y = 10'd5;
         end
         OP_PAUSE_ORIGIN: begin
            bus.btn_pause = 1'b1; bus.x = 10'd0; bus.y = 10'd0;
            @(negedge clk);
            bus.btn_pause = 1'b0; bus.x = 10'd5; bus.y = 10'd5;
         end
         default: @(negedge clk);
      endcase
      #1;
   endtask

   function automatic vec_t mk(op_e op, int a, int b, int sel, int en, int fc, int pend,
                               int paused, int nf, int nfl);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.sel = sel; v.en = en; v.fc = fc;
      v.pend = pend; v.paused = paused; v.nf = nf; v.nf_last = nfl;
      return v;
   endfunction

   task automatic chk_outputs(input string tag, input int sel, input int en, input int fc,
                              input int pend, input int paused);
      chk({tag, ".sel"},    int'(bus.pattern_select), sel);
      chk({tag, ".en"},     int'(bus.pattern_enable), en);
      chk({tag, ".fc"},     int'(bus.frame_count),    fc);
      chk({tag, ".pend"},   int'(bus.switch_pending), pend);
      chk({tag, ".paused"}, int'(bus.paused),         paused);
   endtask

   initial begin
      int nf_base;
      n_cmp = 0; n_bad = 0; nf_cnt = 0; nf_last = 0;
      rst_n = 1'b0;
      bus.x = 10'd5; bus.y = 10'd5; bus.vsync = 1'b1;
      bus.btn_next = 1'b0; bus.btn_pause = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_frames = '0;

      //         op               a     b  sel en  fc   pend pau nf    nf_last
      vecs.push_back(mk(OP_FRAMES,       239, 0, 0, 1, 239,  0, 0, 239,  1));
      vecs.push_back(mk(OP_FRAMES,       1,   0, 0, 1, 0,    1, 0, 1,    1));
      vecs.push_back(mk(OP_FRAMES,       2,   0, 0, 1, 0,    1, 0, 2,    1));
      vecs.push_back(mk(OP_ORIGIN,       0,   0, 1, 2, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_CFG,          1,   3, 1, 2, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       2,   0, 1, 2, 2,    0, 0, 2,    2));
      vecs.push_back(mk(OP_PAUSE,        0,   0, 1, 2, 2,    0, 1, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       50,  0, 1, 2, 2,    0, 1, 0,    0));
      vecs.push_back(mk(OP_PAUSE,        0,   0, 1, 2, 2,    0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       1,   0, 1, 2, 0,    1, 0, 1,    2));
      vecs.push_back(mk(OP_ORIGIN,       0,   0, 2, 4, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_NEXT,         0,   0, 2, 4, 0,    1, 0, 0,    0));
      vecs.push_back(mk(OP_NEXT,         0,   0, 2, 4, 0,    1, 0, 0,    0));
      vecs.push_back(mk(OP_ORIGIN,       0,   0, 3, 8, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_CFG,          3,   2, 3, 8, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       1,   0, 3, 8, 1,    0, 0, 1,    8));
      vecs.push_back(mk(OP_NEXT_FRAME,   0,   0, 3, 8, 0,    1, 0, 1,    8));
      vecs.push_back(mk(OP_NEXT,         0,   0, 3, 8, 0,    1, 0, 0,    0));
      vecs.push_back(mk(OP_ORIGIN,       0,   0, 0, 1, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       12,  0, 0, 1, 12,   0, 0, 12,   1));
      vecs.push_back(mk(OP_CFG,          0,   3, 0, 1, 12,   0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       1,   0, 0, 1, 0,    1, 0, 1,    1));
      vecs.push_back(mk(OP_CFG,          0,   0, 0, 1, 0,    1, 0, 0,    0));
      vecs.push_back(mk(OP_ORIGIN,       0,   0, 1, 2, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_CFG,          1,   0, 1, 2, 0,    0, 0, 0,    0));
      vecs.push_back(mk(OP_FRAMES,       1000,0, 1, 2, 1000, 0, 0, 1000, 2));
      vecs.push_back(mk(OP_FRAMES,       30,  0, 1, 2, 1023, 0, 0, 30,   2));
      vecs.push_back(mk(OP_NEXT,         0,   0, 1, 2, 1023, 1, 0, 0,    0));
      vecs.push_back(mk(OP_ORIGIN_FRAME, 0,   0, 2, 4, 0,    0, 0, 1,    2));
      vecs.push_back(mk(OP_NEXT,         0,   0, 2, 4, 0,    1, 0, 0,    0));
      vecs.push_back(mk(OP_PAUSE_ORIGIN, 0,   0, 3, 8, 0,    0, 1, 0,    0));

      repeat (2) @(negedge clk);
      #1;
      chk_outputs("reset", 0, 1, 0, 0, 0);
      chk("reset.nf", int'(bus.next_frame), 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         string tag;
         tag = $sformatf("v%0d", i);
         nf_base = nf_cnt;
         run_op(vecs[i].op, vecs[i].a, vecs[i].b);
         chk_outputs(tag, vecs[i].sel, vecs[i].en, vecs[i].fc, vecs[i].pend, vecs[i].paused);
         chk({tag, ".nf_cnt"}, nf_cnt - nf_base, vecs[i].nf);
         if (vecs[i].nf > 0) chk({tag, ".nf_last"}, nf_last, vecs[i].nf_last);
      end

      // Reset asserted mid-line while a switch is pending must discard it.
      run_op(OP_NEXT, 0, 0);
      chk("rstpend.pend", int'(bus.switch_pending), 1);
      bus.x = 10'd100; bus.y = 10'd3;
      #2;
      rst_n = 1'b0;
      #1;
      chk_outputs("async_rst", 0, 1, 0, 0, 0);
      chk("async_rst.nf", int'(bus.next_frame), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      bus.x = 10'd5; bus.y = 10'd5;
      run_op(OP_ORIGIN, 0, 0);
      chk_outputs("post_rst", 0, 1, 0, 0, 0);
      nf_base = nf_cnt;
      run_op(OP_FRAMES, 3, 0);
      chk_outputs("post_rst_run", 0, 1, 3, 0, 0);
      chk("post_rst_run.nf_cnt", nf_cnt - nf_base, 3);
      chk("post_rst_run.nf_last", nf_last, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
